sseg_ctrl: RTL and testbench

Display-link controller for the serially driven 8-digit seven-segment module (MAX7219-style 16-bit command words over sclk/load/sdo). After reset it sends the display configuration sequence, then streams the eight digit registers whenever a new segment frame is posted. It also services intensity-change requests by rewriting the intensity register. It arbitrates all of these onto the single serial link, and sits between the segment decoder/button logic and the board pins.

---
 rtl/sseg_pkg.sv | 51 +++++
 rtl/sseg_ser16.sv | 139 +++++++++++++
 rtl/sseg_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_sseg_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// sseg_pkg: shared definitions for the seven-segment display link.
//   - Register addresses of the MAX7219-style display driver.
//   - Controller and serializer state encodings.
//   - Helpers that assemble 16-bit command words.
package sseg_pkg;

    localparam logic [3:0] REG_DIG0      = 4'd1;
    localparam logic [3:0] REG_DECODE    = 4'd9;
    localparam logic [3:0] REG_INTENSITY = 4'd10;
    localparam logic [3:0] REG_SCANLIM   = 4'd11;
    localparam logic [3:0] REG_SHUTDOWN  = 4'd12;
    localparam logic [3:0] REG_TEST      = 4'd15;

    // Number of words in the power-up configuration sequence.
    localparam logic [2:0] INIT_LEN = 3'd5;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_INT   = 2'd2,
        ST_FRAME = 2'd3
    } ctrl_state_e;

    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_LOW  = 2'd1,
        PH_HIGH = 2'd2,
        PH_GAP  = 2'd3
    } ser_phase_e;

    function automatic logic [15:0] mk_word(input logic [3:0] addr, input logic [7:0] data);
        return {4'h0, addr, data};
    endfunction

    // Configuration word idx of the power-up sequence.
    function automatic logic [15:0] init_word(input logic [2:0] idx,
                                              input logic [3:0] inten,
                                              input logic [2:0] scan);
        logic [15:0] w;
        case (idx)
            3'd0:    w = mk_word(REG_TEST,      8'h00);
            3'd1:    w = mk_word(REG_DECODE,    8'h00);
            3'd2:    w = mk_word(REG_INTENSITY, {4'h0, inten});
            3'd3:    w = mk_word(REG_SCANLIM,   {5'h00, scan});
            3'd4:    w = mk_word(REG_SHUTDOWN,  8'h01);
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sseg_ser16.sv
// sseg_ser16: shifts one 16-bit command word out MSB first.
//   clk, rst           : clock, asynchronous active-high reset
//   start_i, word_i    : accepted when ready_o is high
//   ready_o            : idle, or in the last cycle of the load-high gap
//                        (allows back-to-back words with no idle cycle)
//   done_o             : one-cycle pulse in the first gap cycle (word latched)
//   sclk_o/load_o/sdo_o: registered link pins
module sseg_ser16
    import sseg_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [15:0] word_i,
    output logic        ready_o,
    output logic        done_o,
    output logic        sclk_o,
    output logic        load_o,
    output logic        sdo_o
);

    localparam int unsigned    DW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0]  DIV_ONE  = DW'(1);
    localparam logic [DW-1:0]  DIV_ZERO = DW'(0);

    ser_phase_e  phase_q, phase_d;
    logic [DW-1:0] div_q, div_d;
    logic [3:0]  bit_q, bit_d;
    logic [15:0] shreg_q, shreg_d;
    logic        sclk_q, sclk_d;
    logic        load_q, load_d;
    logic        sdo_q, sdo_d;
    logic        last_div_s;
    logic        ready_s;

    assign last_div_s = (div_q == DIV_LAST);
    assign ready_s    = (phase_q == PH_IDLE) || ((phase_q == PH_GAP) && last_div_s);
    assign ready_o    = ready_s;
    assign done_o     = (phase_q == PH_GAP) && (div_q == DIV_ZERO);
    assign sclk_o     = sclk_q;
    assign load_o     = load_q;
    assign sdo_o      = sdo_q;

    // Next-state for the bit/phase sequencer and pin values.
    always_comb begin
        phase_d = phase_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        sclk_d  = sclk_q;
        load_d  = load_q;
        sdo_d   = sdo_q;
        if (ready_s && start_i) begin
            // Bit 15 goes out immediately; the rest wait in shreg.
            phase_d = PH_LOW;
            div_d   = DIV_ZERO;
            bit_d   = 4'd15;
            shreg_d = {word_i[14:0], 1'b0};
            sdo_d   = word_i[15];
            sclk_d  = 1'b0;
            load_d  = 1'b0;
        end else begin
            case (phase_q)
                PH_IDLE: begin
                    sclk_d = 1'b0;
                    load_d = 1'b1;
                    sdo_d  = 1'b0;
                end
                PH_LOW: begin
                    if (last_div_s) begin
                        phase_d = PH_HIGH;
                        div_d   = DIV_ZERO;
                        sclk_d  = 1'b1;
                    end else begin
                        div_d = div_q + DIV_ONE;
                    end
                end
                PH_HIGH: begin
                    if (last_div_s && (bit_q == 4'd0)) begin
                        phase_d = PH_GAP;
                        div_d   = DIV_ZERO;
                        sclk_d  = 1'b0;
                        load_d  = 1'b1;
                        sdo_d   = 1'b0;
                    end else if (last_div_s) begin
                        phase_d = PH_LOW;
                        div_d   = DIV_ZERO;
                        sclk_d  = 1'b0;
                        sdo_d   = shreg_q[15];
                        shreg_d = {shreg_q[14:0], 1'b0};
                        bit_d   = bit_q - 4'd1;
                    end else begin
                        div_d = div_q + DIV_ONE;
                    end
                end
                PH_GAP: begin
                    if (last_div_s) begin
                        phase_d = PH_IDLE;
                        div_d   = DIV_ZERO;
                    end else begin
                        div_d = div_q + DIV_ONE;
                    end
                end
                default: begin
                    phase_d = PH_IDLE;
                    div_d   = DIV_ZERO;
                    sclk_d  = 1'b0;
                    load_d  = 1'b1;
                    sdo_d   = 1'b0;
                end
            endcase
        end
    end

    // Sequencer and pin registers; reset abandons any word in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= PH_IDLE;
            div_q   <= DIV_ZERO;
            bit_q   <= 4'd0;
            shreg_q <= 16'h0000;
            sclk_q  <= 1'b0;
            load_q  <= 1'b1;
            sdo_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            sclk_q  <= sclk_d;
            load_q  <= load_d;
            sdo_q   <= sdo_d;
        end
    end

endmodule

// File: rtl/sseg_ctrl.sv
// sseg_ctrl: display-link controller for an 8-digit serial seven-segment module.
//   clk, rst        : clock, asynchronous active-high reset
//   seg[63:0]       : segment frame, digit k = seg[8k+7:8k]
//   seg_upd         : pulse, frame is new -> schedule refresh
//   int_up, int_dn  : pulses, saturating intensity +1 / -1
//   intensity[3:0]  : current intensity
//   busy            : a word is in flight or work is pending
//   sclk, load, sdo : serial link pins
// Sends the configuration sequence after reset, then serves intensity
// rewrites and eight-digit frame refreshes; a pending intensity change
// is slotted in at any word boundary of a frame.
module sseg_ctrl
    import sseg_pkg::*;
#(
    parameter int unsigned CLK_DIV        = 4,
    parameter logic [3:0]  INIT_INTENSITY = 4'h8,
    parameter logic [2:0]  SCAN_LIMIT     = 3'h7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] seg,
    input  logic        seg_upd,
    input  logic        int_up,
    input  logic        int_dn,
    output logic [3:0]  intensity,
    output logic        busy,
    output logic        sclk,
    output logic        load,
    output logic        sdo
);

    ctrl_state_e state_q, state_d;
    logic [2:0]  init_idx_q, init_idx_d;
    logic [3:0]  dig_idx_q, dig_idx_d;     // next digit to send, 8 = all sent
    logic [63:0] snap_q, snap_d;
    logic        int_pend_q, int_pend_d;
    logic        frame_pend_q, frame_pend_d;
    logic [3:0]  intensity_q, intensity_d;
    logic        busy_q, busy_d;

    logic        inc_s, dec_s;
    logic        int_clr_s, frame_clr_s;
    logic        start_s;
    logic [15:0] word_s;
    logic        ser_ready_s, ser_done_s;

    sseg_ser16 #(
        .CLK_DIV (CLK_DIV)
    ) u_ser (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_s),
        .word_i  (word_s),
        .ready_o (ser_ready_s),
        .done_o  (ser_done_s),
        .sclk_o  (sclk),
        .load_o  (load),
        .sdo_o   (sdo)
    );

    // Opposing pulses in one cycle cancel; a saturated step is not a change.
    assign inc_s = int_up && !int_dn && (intensity_q != 4'hF);
    assign dec_s = int_dn && !int_up && (intensity_q != 4'h0);

    // Controller: choose the next word at each serializer boundary.
    always_comb begin
        state_d     = state_q;
        init_idx_d  = init_idx_q;
        dig_idx_d   = dig_idx_q;
        snap_d      = snap_q;
        start_s     = 1'b0;
        word_s      = 16'h0000;
        int_clr_s   = 1'b0;
        frame_clr_s = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (ser_ready_s && (init_idx_q != INIT_LEN)) begin
                    start_s    = 1'b1;
                    word_s     = init_word(init_idx_q, intensity_q, SCAN_LIMIT);
                    init_idx_d = init_idx_q + 3'd1;
                end else if (ser_done_s && (init_idx_q == INIT_LEN)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_IDLE: begin
                if (ser_ready_s && int_pend_q) begin
                    start_s   = 1'b1;
                    word_s    = mk_word(REG_INTENSITY, {4'h0, intensity_q});
                    int_clr_s = 1'b1;
                    state_d   = ST_INT;
                end else if (ser_ready_s && frame_pend_q) begin
                    // Digit 0 comes straight from seg, which is also the snapshot.
                    start_s     = 1'b1;
                    word_s      = mk_word(REG_DIG0, seg[7:0]);
                    snap_d      = seg;
                    frame_clr_s = 1'b1;
                    dig_idx_d   = 4'd1;
                    state_d     = ST_FRAME;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_INT: begin
                if (ser_done_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_INT;
                end
            end
            ST_FRAME: begin
                if (ser_ready_s && int_pend_q) begin
                    start_s   = 1'b1;
                    word_s    = mk_word(REG_INTENSITY, {4'h0, intensity_q});
                    int_clr_s = 1'b1;
                end else if (ser_ready_s && (dig_idx_q < 4'd8)) begin
                    start_s   = 1'b1;
                    word_s    = mk_word(REG_DIG0 + {1'b0, dig_idx_q[2:0]},
                                        snap_q[{dig_idx_q[2:0], 3'b000} +: 8]);
                    dig_idx_d = dig_idx_q + 4'd1;
                end else if (ser_done_s && (dig_idx_q == 4'd8)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FRAME;
                end
            end
            default: begin
                state_d    = ST_INIT;
                init_idx_d = 3'd0;
            end
        endcase
    end

    // Intensity counter and pending flags; a new request beats a same-cycle clear.
    always_comb begin
        if (inc_s) begin
            intensity_d = intensity_q + 4'd1;
        end else if (dec_s) begin
            intensity_d = intensity_q - 4'd1;
        end else begin
            intensity_d = intensity_q;
        end
        if (inc_s || dec_s) begin
            int_pend_d = 1'b1;
        end else if (int_clr_s) begin
            int_pend_d = 1'b0;
        end else begin
            int_pend_d = int_pend_q;
        end
        if (seg_upd) begin
            frame_pend_d = 1'b1;
        end else if (frame_clr_s) begin
            frame_pend_d = 1'b0;
        end else begin
            frame_pend_d = frame_pend_q;
        end
        busy_d = (state_d != ST_IDLE) || int_pend_d || frame_pend_d;
    end

    // Controller state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_INIT;
            init_idx_q   <= 3'd0;
            dig_idx_q    <= 4'd0;
            snap_q       <= 64'h0;
            int_pend_q   <= 1'b0;
            frame_pend_q <= 1'b0;
            intensity_q  <= INIT_INTENSITY;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            init_idx_q   <= init_idx_d;
            dig_idx_q    <= dig_idx_d;
            snap_q       <= snap_d;
            int_pend_q   <= int_pend_d;
            frame_pend_q <= frame_pend_d;
            intensity_q  <= intensity_d;
            busy_q       <= busy_d;
        end
    end

    assign intensity = intensity_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sseg_ctrl.sv
// tb_sseg_ctrl: self-checking bench for sseg_ctrl.
// Words are recovered from the pins (sdo sampled while sclk is high,
// accepted when load rises after 16 bits) and compared in order against
// a word list built from the display protocol rules.
module tb_sseg_ctrl;

    localparam int CLK_DIV = 4;
    localparam int WP      = 33 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] seg = 64'h0;
    logic        seg_upd = 1'b0;
    logic        int_up = 1'b0;
    logic        int_dn = 1'b0;
    logic [3:0]  intensity;
    logic        busy, sclk, load, sdo;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    sseg_ctrl #(
        .CLK_DIV        (CLK_DIV),
        .INIT_INTENSITY (4'h8),
        .SCAN_LIMIT     (3'h7)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seg       (seg),
        .seg_upd   (seg_upd),
        .int_up    (int_up),
        .int_dn    (int_dn),
        .intensity (intensity),
        .busy      (busy),
        .sclk      (sclk),
        .load      (load),
        .sdo       (sdo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- pin monitor ----------------
    logic [15:0] got_q[$];
    int          fall_cyc_q[$];
    int          n_fall = 0;
    int          last_rise = 0;
    logic        p_load = 1'b1;
    logic        p_sclk = 1'b0;
    logic [15:0] sh = 16'h0;
    int          nb = 0;

    always @(negedge clk) begin
        if (rst) begin
            nb <= 0;
        end else if (p_load && !load) begin
            fall_cyc_q.push_back(cyc);
            n_fall <= n_fall + 1;
            nb <= 0;
        end else if (!load && !p_sclk && sclk) begin
            sh <= {sh[14:0], sdo};
            nb <= nb + 1;
        end else if (!p_load && load) begin
            last_rise <= cyc;
            if (nb == 16) got_q.push_back(sh);
            nb <= 0;
        end
        p_load <= load;
        p_sclk <= sclk;
    end

    // ---------------- reference model ----------------
    logic [15:0] exp_q[$];
    int          m_int = 8;

    function automatic void push_init();
        exp_q.push_back(16'h0F00);
        exp_q.push_back(16'h0900);
        exp_q.push_back(16'h0A00 | 16'(m_int));
        exp_q.push_back(16'h0B07);
        exp_q.push_back(16'h0C01);
    endfunction

    function automatic void push_frame(input logic [63:0] v, input int from, input int to);
        for (int d = from; d <= to; d++)
            exp_q.push_back({4'h0, 4'(d + 1), v[8*d +: 8]});
    endfunction

    function automatic void model_int(input bit up, input bit dn);
        int nv = m_int;
        if (up && !dn) nv = (m_int == 15) ? 15 : m_int + 1;
        else if (dn && !up) nv = (m_int == 0) ? 0 : m_int - 1;
        if (nv != m_int) begin
            m_int = nv;
            exp_q.push_back(16'h0A00 | 16'(nv));
        end
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input bit up, input bit dn, input bit upd);
        @(negedge clk);
        int_up = up; int_dn = dn; seg_upd = upd;
        @(negedge clk);
        int_up = 1'b0; int_dn = 1'b0; seg_upd = 1'b0;
    endtask

    task automatic wait_idle(output int low_cyc);
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        low_cyc = cyc;
        chk("busy idle", {63'h0, busy}, 64'h0);
        repeat (2 * CLK_DIV + 2) @(negedge clk);
    endtask

    task automatic wait_falls(input int target);
        int n = 0;
        while (n_fall < target && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("load fall reached", 64'(n_fall >= target), 64'h1);
    endtask

    task automatic check_words(input string tag);
        int n = 0;
        while (got_q.size() < exp_q.size() && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " count"}, 64'(got_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0)
            chk(tag, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
        exp_q.delete();
        got_q.delete();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int lc, e1, t0, base, op;
        logic [63:0] va;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst sclk", {63'h0, sclk}, 64'h0);
        chk("rst load", {63'h0, load}, 64'h1);
        chk("rst sdo", {63'h0, sdo}, 64'h0);
        chk("rst intensity", {60'h0, intensity}, 64'h8);
        chk("rst busy", {63'h0, busy}, 64'h1);

        // Init sequence: five words, one word period apart
        fall_cyc_q.delete();
        t0 = cyc;
        rst = 1'b0;
        push_init();
        wait_idle(lc);
        chk("init busy drop", 64'(lc), 64'(last_rise + 1));
        chk("init fall count", 64'(fall_cyc_q.size()), 64'd5);
        for (int k = 0; k < fall_cyc_q.size() && k < 5; k++)
            chk("init load period", 64'(fall_cyc_q[k]), 64'(t0 + 1 + k * WP));
        check_words("init word");

        // Directed frame from IDLE, with start latency
        fall_cyc_q.delete();
        seg = 64'h0123456789ABCDEF;
        @(negedge clk);
        e1 = cyc + 1;
        seg_upd = 1'b1;
        @(negedge clk);
        seg_upd = 1'b0;
        push_frame(seg, 0, 7);
        wait_idle(lc);
        chk("frame latency", 64'(fall_cyc_q.size() > 0 ? fall_cyc_q[0] : -1), 64'(e1 + 1));
        check_words("frame word");

        // Intensity change while digit 3 is on the wire
        va = {$urandom, $urandom};
        seg = va;
        base = n_fall;
        pulse(1'b0, 1'b0, 1'b1);
        wait_falls(base + 4);
        repeat (40) @(negedge clk);
        pulse(1'b1, 1'b0, 1'b0);
        push_frame(va, 0, 3);
        model_int(1'b1, 1'b0);
        push_frame(va, 4, 7);
        wait_idle(lc);
        check_words("int insert");
        chk("intensity after insert", {60'h0, intensity}, 64'd9);

        // Saturate at 15, then at 0
        for (int i = 0; i < 8; i++) begin
            pulse(1'b1, 1'b0, 1'b0);
            model_int(1'b1, 1'b0);
            wait_idle(lc);
        end
        check_words("sat up");
        chk("intensity max", {60'h0, intensity}, 64'd15);
        for (int i = 0; i < 17; i++) begin
            pulse(1'b0, 1'b1, 1'b0);
            model_int(1'b0, 1'b1);
            wait_idle(lc);
        end
        check_words("sat down");
        chk("intensity min", {60'h0, intensity}, 64'd0);

        // Two updates during one frame: one more frame with the latest data
        va = {$urandom, $urandom};
        seg = va;
        base = n_fall;
        pulse(1'b0, 1'b0, 1'b1);
        wait_falls(base + 3);
        repeat (30) @(negedge clk);
        seg = {$urandom, $urandom};
        pulse(1'b0, 1'b0, 1'b1);
        wait_falls(base + 6);
        repeat (30) @(negedge clk);
        seg = {64{1'b1}};
        pulse(1'b0, 1'b0, 1'b1);
        push_frame(va, 0, 7);
        push_frame({64{1'b1}}, 0, 7);
        wait_idle(lc);
        check_words("double update");

        // Random operations
        for (int i = 0; i < 10; i++) begin
            op = $urandom_range(0, 3);
            if (op == 3) begin
                va = {$urandom, $urandom};
                seg = va;
                pulse(1'b0, 1'b0, 1'b1);
                push_frame(va, 0, 7);
            end else begin
                pulse(op == 0 || op == 2, op == 1 || op == 2, 1'b0);
                model_int(op == 0 || op == 2, op == 1 || op == 2);
            end
            wait_idle(lc);
            check_words("random word");
            chk("random intensity", {60'h0, intensity}, 64'(m_int));
        end

        // Reset at bit 7 of digit 2
        va = {$urandom, $urandom};
        seg = va;
        base = n_fall;
        pulse(1'b0, 1'b0, 1'b1);
        wait_falls(base + 3);
        repeat (8 * 2 * CLK_DIV + 2) @(negedge clk);
        chk("pre-reset load", {63'h0, load}, 64'h0);
        #2 rst = 1'b1;
        #1;
        chk("mid-word rst load", {63'h0, load}, 64'h1);
        chk("mid-word rst sclk", {63'h0, sclk}, 64'h0);
        chk("mid-word rst intensity", {60'h0, intensity}, 64'h8);
        push_frame(va, 0, 1);
        repeat (3) @(negedge clk);
        check_words("pre-reset word");

        fall_cyc_q.delete();
        m_int = 8;
        t0 = cyc;
        rst = 1'b0;
        push_init();
        wait_idle(lc);
        chk("reinit first fall", 64'(fall_cyc_q.size() > 0 ? fall_cyc_q[0] : -1), 64'(t0 + 1));
        check_words("reinit word");

        // Simultaneous up and down: no change, no word
        pulse(1'b1, 1'b1, 1'b0);
        model_int(1'b1, 1'b1);
        wait_idle(lc);
        check_words("up+dn");
        chk("up+dn intensity", {60'h0, intensity}, 64'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
